// File: rtl/valve_chain_sequencer.sv
// rtl/valve_chain_sequencer.sv - peristaltic valve-chain sequencer with HOLD/FLUSH/PUMP modes
// Optional VALVE_SEQ_ACT_COUNT_EN adds a saturating valve-opening counter (act_count).
module valve_chain_sequencer #(
    parameter  int NUM_VALVES = 4,
    parameter  int STEP_W     = 16,
    parameter  int CYC_W      = 16,
    localparam int PH_W       = $clog2(NUM_VALVES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic [CYC_W-1:0]      cmd_cycles,
    input  logic [STEP_W-1:0]     cmd_step,
    input  logic                  abort,
    output logic [NUM_VALVES-1:0] valve_close,
    output logic                  busy,
    output logic                  done,
`ifdef VALVE_SEQ_ACT_COUNT_EN
    output logic [31:0]           act_count,
`endif
    output logic [PH_W-1:0]       phase
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SETTLE} state_t;
    typedef enum logic [1:0] {MODE_HOLD, MODE_FLUSH, MODE_FWD, MODE_REV} mode_t;

    state_t            state, state_nxt;
    mode_t             mode_r;
    logic [CYC_W-1:0]  cycles_r;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [STEP_W-1:0] p_last;
    logic [STEP_W-1:0] step_cnt;
    logic              accept;
    logic              step_last;
    logic              phase_last;
    logic              cycles_last;

    assign accept      = cmd_valid && (state == ST_IDLE);
    assign step_last   = (step_cnt == p_last);
    assign phase_last  = (phase == PH_W'(NUM_VALVES - 1));
    assign cycles_last = ((cyc_cnt + CYC_W'(1)) == cycles_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = (cmd_cycles == '0) ? ST_SETTLE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort || (step_last && phase_last && cycles_last)) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (step_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A zero step field is stored as a one-clock step (terminal count 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r   <= MODE_HOLD;
            cycles_r <= '0;
            cyc_cnt  <= '0;
            p_last   <= '0;
            step_cnt <= '0;
            phase    <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == ST_SETTLE) && step_last;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mode_r   <= mode_t'(cmd_mode);
                        cycles_r <= cmd_cycles;
                        p_last   <= (cmd_step == '0) ? '0 : cmd_step - STEP_W'(1);
                        cyc_cnt  <= '0;
                        step_cnt <= '0;
                        phase    <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        step_cnt <= '0;
                        phase    <= '0;
                    end else if (step_last) begin
                        step_cnt <= '0;
                        if (phase_last) begin
                            phase   <= '0;
                            cyc_cnt <= cyc_cnt + CYC_W'(1);
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end else begin
                        step_cnt <= step_cnt + STEP_W'(1);
                    end
                end
                ST_SETTLE: begin
                    step_cnt <= step_last ? '0 : step_cnt + STEP_W'(1);
                end
                default: begin
                    step_cnt <= '0;
                    phase    <= '0;
                end
            endcase
        end
    end

    // Pump patterns open exactly one valve, so a step change swaps one open valve for another.
    always_comb begin
        valve_close = '1;
        if (state == ST_RUN) begin
            case (mode_r)
                MODE_HOLD:  valve_close = '1;
                MODE_FLUSH: valve_close = '0;
                MODE_FWD: begin
                    for (int i = 0; i < NUM_VALVES; i++) begin
                        valve_close[i] = (PH_W'(i) != phase);
                    end
                end
                MODE_REV: begin
                    for (int i = 0; i < NUM_VALVES; i++) begin
                        valve_close[i] = (PH_W'(NUM_VALVES - 1 - i) != phase);
                    end
                end
                default: valve_close = '1;
            endcase
        end
    end

`ifdef VALVE_SEQ_ACT_COUNT_EN
    logic [NUM_VALVES-1:0] close_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            close_q   <= '1;
            act_count <= '0;
        end else begin
            close_q <= valve_close;
            if ((|(close_q & ~valve_close)) && (act_count != 32'hFFFF_FFFF)) begin
                act_count <= act_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_valve_chain_sequencer.sv
// tb/tb_valve_chain_sequencer.sv - randomized self-checking bench against a trace model
// Build with VALVE_SEQ_ACT_COUNT_EN defined to also exercise act_count.
module tb_valve_chain_sequencer;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_cycles;
    logic [15:0] cmd_step;
    logic        abort;
    logic [3:0]  valve_close;
    logic        busy;
    logic        done;
    logic [1:0]  phase;
`ifdef VALVE_SEQ_ACT_COUNT_EN
    logic [31:0] act_count;
`endif

    int errors = 0;
    int checks = 0;

    valve_chain_sequencer #(.NUM_VALVES(N), .STEP_W(16), .CYC_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .cmd_cycles  (cmd_cycles),
        .cmd_step    (cmd_step),
        .abort       (abort),
        .valve_close (valve_close),
        .busy        (busy),
        .done        (done),
`ifdef VALVE_SEQ_ACT_COUNT_EN
        .act_count   (act_count),
`endif
        .phase       (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] pattern(input int mode, input int s);
        case (mode)
            0:       return 4'b1111;
            1:       return 4'b0000;
            2:       return ~(4'b0001 << s);
            default: return ~(4'b0001 << (N - 1 - s));
        endcase
    endfunction

    // Issues one command and checks every clock up to and including the done clock.
    // ab = 1-based clock (counted from acceptance) in which abort is held high; 0 = none.
    task automatic run_cmd(input int mode, input int cycles, input int step, input int ab);
        int p, run_len, len, s;
        p       = (step == 0) ? 1 : step;
        run_len = cycles * N * p;
        if (ab > 0 && ab <= run_len) run_len = ab;
        len     = run_len + p;

        @(negedge clk);
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_mode   = 2'(mode);
        cmd_cycles = 16'(cycles);
        cmd_step   = 16'(step);
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_mode   = 2'($urandom_range(0, 3));
        cmd_cycles = 16'($urandom_range(1, 3));
        cmd_step   = 16'($urandom_range(0, 3));

        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            abort = (ab > 0 && k == ab - 1);
            if (len > 2) cmd_valid = (k == 0);
            check("busy", 32'(busy), 32'd1);
            check("ready_busy", 32'(cmd_ready), 32'd0);
            check("done_early", 32'(done), 32'd0);
            if (k < run_len) begin
                s = (k / p) % N;
                check("run_valves", 32'(valve_close), 32'(pattern(mode, s)));
                check("phase", 32'(phase), 32'(s));
            end else begin
                check("settle_valves", 32'(valve_close), 32'hF);
            end
        end
        @(negedge clk);
        abort     = 1'b0;
        cmd_valid = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_fall", 32'(busy), 32'd0);
        check("ready_done", 32'(cmd_ready), 32'd1);
        check("idle_valves", 32'(valve_close), 32'hF);
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_mode   = 2'd0;
        cmd_cycles = 16'd0;
        cmd_step   = 16'd0;
        abort      = 1'b0;
        #12;
        check("rst_valves", 32'(valve_close), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            abort = (i == 1);
            check("idle_valves", 32'(valve_close), 32'hF);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_ready", 32'(cmd_ready), 32'd1);
        end
        abort = 1'b0;

        run_cmd(2, 1, 2, 0);
        run_cmd(3, 2, 0, 0);
        run_cmd(1, 5, 3, 7);
        run_cmd(0, 0, 4, 0);
        run_cmd(2, 1, 1, 6);

        for (int t = 0; t < 30; t++) begin
            int ab;
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 14)) : 0;
            run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), ab);
        end

        // Asynchronous reset in the middle of a forward pump.
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_mode   = 2'd2;
        cmd_cycles = 16'd3;
        cmd_step   = 16'd2;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valves", 32'(valve_close), 32'hF);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

`ifdef VALVE_SEQ_ACT_COUNT_EN
        rst_n = 1'b0;
        #1;
        check("act_rst", act_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(2, 3, 1, 0);
        check("act_fwd", act_count, 32'd12);
        run_cmd(0, 2, 1, 0);
        check("act_hold", act_count, 32'd12);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
